// File: rtl/pipe_hazard_track_if.sv
// Bundles the fetch, decode and hazard inputs of pipe_hazard_track with its
// IF/ID and scoreboard outputs.
//   master : drives the fetch/decode/hazard signals, observes the outputs
//   slave  : the tracker itself
interface pipe_hazard_track_if;
  // fetch side
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  // decode of the instruction currently in IF/ID
  logic        dec_is_lw;
  logic        dec_write;
  logic [4:0]  dec_w_addr;
  // hazard / control
  logic        is_stall;
  logic        flush;
  // IF/ID register
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        pc_hold;
  // scoreboard stages
  logic        is_lw_id;
  logic        write_id;
  logic [4:0]  w_addr_id;
  logic        is_lw_ex;
  logic        write_ex;
  logic [4:0]  w_addr_ex;
  logic        is_lw_mem;
  logic        write_mem;
  logic [4:0]  w_addr_mem;
  logic [15:0] stall_cnt;

  modport master (
    output if_instr, if_pc, if_valid, dec_is_lw, dec_write, dec_w_addr,
           is_stall, flush,
    input  id_instr, id_pc, id_valid, pc_hold,
           is_lw_id, write_id, w_addr_id,
           is_lw_ex, write_ex, w_addr_ex,
           is_lw_mem, write_mem, w_addr_mem,
           stall_cnt
  );

  modport slave (
    input  if_instr, if_pc, if_valid, dec_is_lw, dec_write, dec_w_addr,
           is_stall, flush,
    output id_instr, id_pc, id_valid, pc_hold,
           is_lw_id, write_id, w_addr_id,
           is_lw_ex, write_ex, w_addr_ex,
           is_lw_mem, write_mem, w_addr_mem,
           stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_track.sv
// IF/ID pipeline register plus a three-deep destination scoreboard used by a
// load-use hazard judge, and a saturating stall-cycle counter.
//   clk : pipeline clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : pipe_hazard_track_if.slave (fetch/decode/hazard in, IF/ID and
//         scoreboard out)
module pipe_hazard_track (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_track_if.slave    bus
);

  typedef struct packed {
    logic       is_lw;
    logic       write;
    logic [4:0] w_addr;
  } sb_t;

  localparam sb_t SB_BUBBLE = '{is_lw: 1'b0, write: 1'b0, w_addr: 5'd0};

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic        id_valid_q, id_valid_d;
  sb_t         sb1_q, sb1_d;
  sb_t         sb2_q;
  sb_t         sb3_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state: a stall freezes IF/ID (and overrides a simultaneous flush);
  // a flush replaces the fetched word with an invalid nop but keeps its PC.
  always_comb begin
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    sb1_d       = SB_BUBBLE;
    stall_cnt_d = stall_cnt_q;
    if (bus.is_stall) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end else begin
      if (bus.flush) begin
        id_instr_d = 32'h0;
        id_pc_d    = bus.if_pc;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = bus.if_instr;
        id_pc_d    = bus.if_pc;
        id_valid_d = bus.if_valid;
      end
      // Invalid IF/ID contents must not claim a destination register.
      sb1_d.is_lw  = bus.dec_is_lw & id_valid_q;
      sb1_d.write  = bus.dec_write & id_valid_q;
      sb1_d.w_addr = bus.dec_w_addr;
    end
  end

  // Stages 2 and 3 shift every edge, even during a stall, so the bubble
  // injected in stage 1 lets a load age out and bounds the stall length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      id_valid_q  <= 1'b0;
      sb1_q       <= SB_BUBBLE;
      sb2_q       <= SB_BUBBLE;
      sb3_q       <= SB_BUBBLE;
      stall_cnt_q <= 16'h0;
    end else begin
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      sb1_q       <= sb1_d;
      sb2_q       <= sb1_q;
      sb3_q       <= sb2_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_hold    = bus.is_stall;
  assign bus.id_instr   = id_instr_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.is_lw_id   = sb1_q.is_lw;
  assign bus.write_id   = sb1_q.write;
  assign bus.w_addr_id  = sb1_q.w_addr;
  assign bus.is_lw_ex   = sb2_q.is_lw;
  assign bus.write_ex   = sb2_q.write;
  assign bus.w_addr_ex  = sb2_q.w_addr;
  assign bus.is_lw_mem  = sb3_q.is_lw;
  assign bus.write_mem  = sb3_q.write;
  assign bus.w_addr_mem = sb3_q.w_addr;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_track.sv
module tb_pipe_hazard_track;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_track_if bus();

  pipe_hazard_track dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       lw;
    bit       wr;
    bit [4:0] a;
  } ent_t;

  bit [31:0] m_instr, m_pc;
  bit        m_valid;
  ent_t      m_sb[$];     // m_sb[0] = youngest (stage 1), m_sb[2] = stage 3
  int        m_cnt;

  task automatic model_reset();
    ent_t z;
    z = '{lw: 0, wr: 0, a: 0};
    m_instr = 0; m_pc = 0; m_valid = 0; m_cnt = 0;
    m_sb = {z, z, z};
  endtask

  // Apply the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    ent_t n;
    bit   v_before;
    v_before = m_valid;
    n = '{lw: 0, wr: 0, a: 0};
    if (bus.is_stall) begin
      if (m_cnt < 65535) m_cnt++;
    end else begin
      n.lw = bus.dec_is_lw && v_before;
      n.wr = bus.dec_write && v_before;
      n.a  = bus.dec_w_addr;
      m_pc = bus.if_pc;
      if (bus.flush) begin
        m_instr = 0; m_valid = 0;
      end else begin
        m_instr = bus.if_instr; m_valid = bus.if_valid;
      end
    end
    void'(m_sb.pop_back());
    m_sb.push_front(n);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".id_instr"}, bus.id_instr, m_instr);
    chk({tag, ".id_pc"},    bus.id_pc,    m_pc);
    chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(m_valid));
    chk({tag, ".sb1"}, {25'd0, bus.is_lw_id,  bus.write_id,  bus.w_addr_id},
        {25'd0, m_sb[0].lw, m_sb[0].wr, m_sb[0].a});
    chk({tag, ".sb2"}, {25'd0, bus.is_lw_ex,  bus.write_ex,  bus.w_addr_ex},
        {25'd0, m_sb[1].lw, m_sb[1].wr, m_sb[1].a});
    chk({tag, ".sb3"}, {25'd0, bus.is_lw_mem, bus.write_mem, bus.w_addr_mem},
        {25'd0, m_sb[2].lw, m_sb[2].wr, m_sb[2].a});
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit st, input bit fl, input bit [31:0] ins,
                       input bit [31:0] pc, input bit v, input bit lw,
                       input bit wr, input bit [4:0] a);
    bus.is_stall = st; bus.flush = fl; bus.if_instr = ins; bus.if_pc = pc;
    bus.if_valid = v; bus.dec_is_lw = lw; bus.dec_write = wr; bus.dec_w_addr = a;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        st, fl;
    bit [31:0] ins, pc;
    bit        v, lw, wr;
    bit [4:0]  a;
    bit [31:0] e_instr, e_pc;
    bit        e_valid, e_lw, e_wr;
    bit [4:0]  e_a;
    bit [15:0] e_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0,0,32'h8C080000,32'h00400000,1,0,0,5'd0,  32'h8C080000,32'h00400000,1,0,0,5'd0, 16'd0};
    vecs[1] = '{0,0,32'h01095020,32'h00400004,1,1,1,5'd8,  32'h01095020,32'h00400004,1,1,1,5'd8, 16'd0};
    vecs[2] = '{1,0,32'hAAAAAAAA,32'h00400008,1,0,1,5'd10, 32'h01095020,32'h00400004,1,0,0,5'd0, 16'd1};
    vecs[3] = '{1,1,32'hBBBBBBBB,32'h0040000C,1,1,1,5'd10, 32'h01095020,32'h00400004,1,0,0,5'd0, 16'd2};
    vecs[4] = '{0,1,32'hCCCCCCCC,32'h00400010,1,0,1,5'd10, 32'h00000000,32'h00400010,0,0,1,5'd10,16'd2};
    vecs[5] = '{0,0,32'h12345678,32'h00400014,0,1,1,5'd5,  32'h12345678,32'h00400014,0,0,0,5'd5, 16'd2};
    vecs[6] = '{0,0,32'h8C0A0004,32'h00400018,1,0,1,5'd3,  32'h8C0A0004,32'h00400018,1,0,0,5'd3, 16'd2};
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    // reset state, with pc_hold following is_stall while in reset
    bus.is_stall = 1'b1;
    #1;
    chk("reset.pc_hold", 32'(bus.pc_hold), 32'd1);
    cmp_model("reset");
    bus.is_stall = 1'b0;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].ins, vecs[i].pc, vecs[i].v,
            vecs[i].lw, vecs[i].wr, vecs[i].a);
      #1;
      chk($sformatf("vec%0d.pc_hold", i), 32'(bus.pc_hold), 32'(vecs[i].st));
      tick();
      chk($sformatf("vec%0d.id_instr", i), bus.id_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d.id_pc", i), bus.id_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.id_valid", i), 32'(bus.id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.sb1", i), {25'd0, bus.is_lw_id, bus.write_id, bus.w_addr_id},
          {25'd0, vecs[i].e_lw, vecs[i].e_wr, vecs[i].e_a});
      chk($sformatf("vec%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(vecs[i].e_cnt));
    end

    // Load propagates to stage 3 two edges after reaching stage 1
    do_reset();
    drive(0, 0, 32'h8C080000, 32'h00400000, 1, 0, 0, 0);
    tick();
    drive(0, 0, 32'h00000000, 32'h00400004, 1, 1, 1, 5'd8);
    tick();
    chk("load.is_lw_id", 32'(bus.is_lw_id), 32'd1);
    chk("load.w_addr_id", 32'(bus.w_addr_id), 32'd8);
    drive(1, 0, 32'h00000000, 32'h00400004, 1, 0, 1, 5'd9);
    tick();
    tick();
    chk("load.is_lw_mem", 32'(bus.is_lw_mem), 32'd1);
    chk("load.w_addr_mem", 32'(bus.w_addr_mem), 32'd8);
    chk("load.is_lw_id_bubble", 32'(bus.is_lw_id), 32'd0);
    tick();
    chk("load.aged_out", 32'(bus.is_lw_mem), 32'd0);
    cmp_model("load");

    // Async reset asserted between edges during a stall
    bus.is_stall = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.id_instr", bus.id_instr, 32'd0);
    chk("arst.id_pc", bus.id_pc, 32'd0);
    chk("arst.scoreboard", {bus.is_lw_id, bus.write_id, bus.w_addr_id,
        bus.is_lw_ex, bus.write_ex, bus.w_addr_ex,
        bus.is_lw_mem, bus.write_mem, bus.w_addr_mem, bus.id_valid}, 32'd0);
    chk("arst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("arst.pc_hold", 32'(bus.pc_hold), 32'd1);
    model_reset();
    rst = 1'b0;
    bus.is_stall = 1'b0;
    drive(0, 0, 32'h11112222, 32'h00400020, 1, 0, 0, 0);
    tick();
    cmp_model("post_rst");

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom,
            $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 1), 5'($urandom));
      #1;
      chk("rand.pc_hold", 32'(bus.pc_hold), 32'(bus.is_stall));
      tick();
      cmp_model($sformatf("rand%0d", n));
    end

    // Saturation of the stall counter
    do_reset();
    drive(1, 0, 32'h0, 32'h0, 1, 1, 1, 5'd1);
    for (int n = 0; n < 65537; n++) tick();
    chk("sat.stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
    tick();
    chk("sat.no_wrap", 32'(bus.stall_cnt), 32'h0000FFFF);
    cmp_model("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_track.md
PIPE_HAZARD_TRACK -- requirements
Module: pipe_hazard_track

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed (32-bit instruction and PC, 5-bit register address, 16-bit counter).
REQ-002 clk  input  1  single pipeline clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_instr  input  32  instruction fetched this cycle.
REQ-005 if_pc  input  32  PC of if_instr.
REQ-006 if_valid  input  1  if_instr/if_pc are meaningful.
REQ-007 dec_is_lw  input  1  the instruction held in id_instr is a load word.
REQ-008 dec_write  input  1  the instruction held in id_instr writes the register file.
REQ-009 dec_w_addr  input  5  destination register of the instruction held in id_instr.
REQ-010 is_stall  input  1  load-use stall request from the hazard judge, computed from id_instr and the scoreboard outputs.
REQ-011 flush  input  1  taken branch/jump resolved in decode; discard the fetched instruction.
REQ-012 id_instr, id_pc  output  32 each  IF/ID pipeline register contents.
REQ-013 id_valid  output  1  id_instr holds a real instruction.
REQ-014 pc_hold  output  1  freeze PC this cycle.
REQ-015 is_lw_id, write_id, w_addr_id (1,1,5)  output  scoreboard stage 1 (one instruction ahead of id_instr).
REQ-016 is_lw_ex, write_ex, w_addr_ex (1,1,5)  output  scoreboard stage 2.
REQ-017 is_lw_mem, write_mem, w_addr_mem (1,1,5)  output  scoreboard stage 3.
REQ-018 stall_cnt  output  16  number of stall cycles since reset.

Function
REQ-019 pc_hold SHALL equal is_stall combinationally (zero latency).
REQ-020 is_stall=1: IF/ID SHALL hold id_instr, id_pc and id_valid unchanged.
REQ-021 is_stall=0, flush=1: IF/ID SHALL load id_instr=32'h0, id_pc=if_pc, id_valid=0.
REQ-022 is_stall=0, flush=0: IF/ID SHALL load if_instr, if_pc, id_valid=if_valid.
REQ-023 Simultaneous is_stall and flush: stall SHALL win; the flush is ignored that cycle, and the source re-asserts flush once the branch resolves.
REQ-024 Stage 1 SHALL load {dec_is_lw & id_valid, dec_write & id_valid, dec_w_addr} when is_stall=0.
REQ-025 Stage 1 SHALL load the bubble {0,0,5'b0} when is_stall=1.
REQ-026 Stage 2 SHALL take stage 1 and stage 3 SHALL take stage 2 on every clock edge, including stall cycles.
REQ-027 Consequence of REQ-025/026: a load-use pair SHALL stall at most three consecutive cycles before is_lw_mem ages out.
REQ-028 stall_cnt SHALL increment by 1 on each edge with is_stall=1.
REQ-029 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-030 An instruction with id_valid=0 SHALL enter stage 1 with write=0 and is_lw=0 regardless of the dec_* inputs.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) clear id_instr, id_pc, id_valid, all scoreboard stages and stall_cnt to 0.
REQ-032 pc_hold SHALL follow is_stall during reset.
REQ-033 After rst is deasserted, the first rising edge SHALL perform a normal update per REQ-020..REQ-029.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction and all scoreboard contents with no residual stall.

Verification
REQ-035 Normal load: if_instr=32'h8C080000, if_pc=32'h00400000, if_valid=1, no stall/flush, one edge -> id_instr=32'h8C080000, id_valid=1; drive dec_is_lw=1, dec_write=1, dec_w_addr=8, one edge -> is_lw_id=1, w_addr_id=8; two more edges -> is_lw_mem=1, w_addr_mem=8.
REQ-036 Stall bubble: is_stall=1 for 3 edges -> id_instr and id_pc unchanged, pc_hold=1, stage 1 receives zeros each edge, stall_cnt=3.
REQ-037 Flush: flush=1, is_stall=0, if_pc=32'h00400010 -> id_instr=0, id_pc=32'h00400010, id_valid=0; next edge with dec_write=1 -> write_id=0.
REQ-038 Priority: is_stall=1 and flush=1 together -> IF/ID unchanged, stall_cnt increments.
REQ-039 Saturation: hold is_stall=1 for 65537 edges -> stall_cnt=16'hFFFF.
REQ-040 Async reset: assert rst between edges during a stall -> all outputs except pc_hold read 0 before the next edge.
